// File: rtl/bkm_irq_pkg.sv
// ---------------------------------------------------------------------------
// bkm_irq_pkg
// Shared definitions for the BKM-68X interrupt scheduler: the INT codes served
// through monitor register 0x41, the detected video-format codes and the
// scheduler FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package bkm_irq_pkg;

  // INT register values (active-low event codes, 0xFF = nothing pending)
  localparam logic [7:0] INT_NONE     = 8'hFF;
  localparam logic [7:0] INT_POWERON  = 8'hFD;
  localparam logic [7:0] INT_ANNOUNCE = 8'hFB;
  localparam logic [7:0] INT_READY    = 8'hEF;
  localparam logic [7:0] INT_FORMAT   = 8'hDF;

  // Detected video-format codes
  localparam logic [7:0] FMT_NONE = 8'd0;
  localparam logic [7:0] FMT_1    = 8'd1;
  localparam logic [7:0] FMT_2    = 8'd2;
  localparam logic [7:0] FMT_3    = 8'd3;
  localparam logic [7:0] FMT_4    = 8'd4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_WAIT_ID,
    S_WAIT_READY,
    S_RUN
  } state_t;

endpackage

// File: rtl/bkm_sec_timebase.sv
// ---------------------------------------------------------------------------
// bkm_sec_timebase
// Divides clk_50mhz_in down to a one-second tick and keeps a saturating count
// of whole seconds since reset.
// Ports:
//   clk_50mhz_in  in   system clock
//   reset_x       in   asynchronous active-low reset
//   tick          out  one-cycle pulse on the last cycle of each second
//   elapsed_s     out  seconds since reset, holds at 255
// ---------------------------------------------------------------------------
module bkm_sec_timebase #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  output logic       tick,
  output logic [7:0] elapsed_s
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;

  assign tick = (prescaler == TERM);

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      prescaler <= '0;
      elapsed_s <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick && (elapsed_s != 8'hFF)) begin
        elapsed_s <= elapsed_s + 8'd1;
      end
    end
  end

endmodule

// File: rtl/bkm_irq_scheduler.sv
// ---------------------------------------------------------------------------
// bkm_irq_scheduler
// Sequences every interrupt raised toward the monitor (power-on, ID announce,
// ready, video-format change, generic requesters) and owns the INT register
// (monitor register 0x41). One event is posted at a time; the next waits until
// the monitor clears the register.
// Optional feature macro: BKM_IRQ_RETRY_EN (uncleared posts are retried three
// times and then dropped, setting the sticky irq_lost output).
// Ports:
//   clk_50mhz_in      in   system clock
//   reset_x           in   asynchronous active-low reset
//   skip_init         in   bypass the boot announce sequence
//   id_read_a         in   monitor has read the ID (clk_rw domain level)
//   irq_clr_tgl_a     in   toggles per monitor write to 0x41 (clk_rw domain)
//   video_format      in   current detected format code
//   ext_req           in   per-requester one-cycle request pulses
//   ext_code          in   per-requester INT code, slice i for requester i
//   ext_grant         out  one-cycle pulse when requester i is posted
//   int_reg           out  register 0x41 value, 0xFF = nothing pending
//   int_pending       out  int_reg != 0xFF
//   reg_video_format  out  last format announced to the monitor
//   elapsed_s         out  seconds since reset, saturating
//   init_done         out  high once the FSM has reached S_RUN
//   irq_lost          out  sticky, an event was dropped (retry build only)
// ---------------------------------------------------------------------------
module bkm_irq_scheduler
  import bkm_irq_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int ANNOUNCE_S = 12,
  parameter int READY_S    = 19,
  parameter int NUM_REQ    = 2,
  parameter int RETRY_S    = 2
) (
  input  logic                 clk_50mhz_in,
  input  logic                 reset_x,
  input  logic                 skip_init,
  input  logic                 id_read_a,
  input  logic                 irq_clr_tgl_a,
  input  logic [7:0]           video_format,
  input  logic [NUM_REQ-1:0]   ext_req,
  input  logic [8*NUM_REQ-1:0] ext_code,
  output logic [NUM_REQ-1:0]   ext_grant,
  output logic [7:0]           int_reg,
  output logic                 int_pending,
  output logic [7:0]           reg_video_format,
  output logic [7:0]           elapsed_s,
`ifdef BKM_IRQ_RETRY_EN
  output logic                 init_done,
  output logic                 irq_lost
`else
  output logic                 init_done
`endif
);

  state_t             state, state_next;
  logic               id_s1, id_sync;
  logic               clr_s1, clr_s2, clr_s3;
  logic               clr_evt, can_post, post, sec_tick;
  logic [7:0]         post_code, fmt_next;
  logic [NUM_REQ-1:0] pend, grant_next;

`ifdef BKM_IRQ_RETRY_EN
  localparam int GAP_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  logic        retry_gap;
  logic [7:0]  retry_sec, last_code;
  logic [1:0]  retry_cnt;
  logic [31:0] gap_cnt;
`else
  logic        unused_ok;
  assign unused_ok = sec_tick & (RETRY_S != 0);
`endif

  bkm_sec_timebase #(.CLK_HZ(CLK_HZ)) u_timebase (
    .clk_50mhz_in (clk_50mhz_in),
    .reset_x      (reset_x),
    .tick         (sec_tick),
    .elapsed_s    (elapsed_s)
  );

  // Two-flop synchronizers; clr_s3 is a delayed copy so any change of the
  // synchronized toggle shows up as a one-cycle clear event.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      id_s1   <= 1'b0;
      id_sync <= 1'b0;
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
      clr_s3  <= 1'b0;
    end else begin
      id_s1   <= id_read_a;
      id_sync <= id_s1;
      clr_s1  <= irq_clr_tgl_a;
      clr_s2  <= clr_s1;
      clr_s3  <= clr_s2;
    end
  end

  assign clr_evt     = clr_s2 ^ clr_s3;
  assign int_pending = (int_reg != INT_NONE);
  assign init_done   = (state == S_RUN);

  // A clear in the same cycle always wins, so posting is held off until the
  // cycle after it.
`ifdef BKM_IRQ_RETRY_EN
  assign can_post = (int_reg == INT_NONE) && !clr_evt && !retry_gap;
`else
  assign can_post = (int_reg == INT_NONE) && !clr_evt;
`endif

  always_comb begin
    state_next = state;
    post       = 1'b0;
    post_code  = INT_NONE;
    fmt_next   = reg_video_format;
    grant_next = '0;
    case (state)
      S_BOOT: begin
        if (int_reg == INT_NONE) begin
          state_next = S_WAIT_ID;
        end else if (skip_init) begin
          state_next = S_RUN;
        end
      end
      S_WAIT_ID: begin
        if (can_post && id_sync && (elapsed_s > 8'(ANNOUNCE_S))) begin
          post       = 1'b1;
          post_code  = INT_ANNOUNCE;
          state_next = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (can_post && (elapsed_s > 8'(READY_S))) begin
          post       = 1'b1;
          post_code  = INT_READY;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Format is compared at service time, so a change that reverts before
        // the register frees up is never announced.
        if (can_post) begin
          if (video_format != reg_video_format) begin
            post      = 1'b1;
            post_code = INT_FORMAT;
            fmt_next  = video_format;
          end else begin
            // Descending scan: the lowest pending index overwrites last.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
              if (pend[i]) begin
                post          = 1'b1;
                post_code     = ext_code[i*8 +: 8];
                grant_next    = '0;
                grant_next[i] = 1'b1;
              end
            end
          end
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  // Request latches collect pulses in any state; a pulse landing on the cycle
  // its requester is granted merges into that grant.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state            <= S_BOOT;
      reg_video_format <= FMT_NONE;
      ext_grant        <= '0;
      pend             <= '0;
    end else begin
      state            <= state_next;
      reg_video_format <= fmt_next;
      ext_grant        <= grant_next;
      pend             <= (pend | ext_req) & ~grant_next;
    end
  end

`ifdef BKM_IRQ_RETRY_EN
  // INT register with retry: an uncleared post is withdrawn after RETRY_S
  // second ticks, left at 0xFF for GAP_CYC cycles, then reposted. The fourth
  // timeout drops the event and sets irq_lost. Any clear cancels the sequence.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      int_reg   <= INT_POWERON;
      last_code <= INT_POWERON;
      retry_sec <= '0;
      retry_cnt <= '0;
      retry_gap <= 1'b0;
      gap_cnt   <= '0;
      irq_lost  <= 1'b0;
    end else if (clr_evt) begin
      int_reg   <= INT_NONE;
      retry_sec <= '0;
      retry_cnt <= '0;
      retry_gap <= 1'b0;
    end else if (retry_gap) begin
      if (gap_cnt == 32'(GAP_CYC - 1)) begin
        retry_gap <= 1'b0;
        int_reg   <= last_code;
        retry_cnt <= retry_cnt + 2'd1;
      end else begin
        gap_cnt <= gap_cnt + 32'd1;
      end
    end else if (int_reg != INT_NONE) begin
      if (sec_tick) begin
        if (retry_sec == 8'(RETRY_S - 1)) begin
          int_reg   <= INT_NONE;
          retry_sec <= '0;
          if (retry_cnt == 2'd3) begin
            irq_lost  <= 1'b1;
            retry_cnt <= '0;
          end else begin
            retry_gap <= 1'b1;
            gap_cnt   <= '0;
          end
        end else begin
          retry_sec <= retry_sec + 8'd1;
        end
      end
    end else if (post) begin
      int_reg   <= post_code;
      last_code <= post_code;
      retry_sec <= '0;
      retry_cnt <= '0;
    end
  end
`else
  // INT register: a clear forces 0xFF, otherwise a granted post lands.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      int_reg <= INT_POWERON;
    end else if (clr_evt) begin
      int_reg <= INT_NONE;
    end else if (post) begin
      int_reg <= post_code;
    end
  end
`endif

endmodule

// File: tb/tb_bkm_irq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bkm_irq_scheduler
// Self-checking bench for bkm_irq_scheduler at CLK_HZ=100: boot sequence,
// a table of S_RUN vectors (arbitration order, clear/post collision, request
// merging, format revert), mid-operation reset with skip_init, seconds
// saturation and, when BKM_IRQ_RETRY_EN is defined, the retry/drop sequence.
// ---------------------------------------------------------------------------
module tb_bkm_irq_scheduler;

  localparam int CLK_HZ = 100;

  typedef struct {
    logic       clr;
    logic [1:0] req;
    logic [7:0] vfmt;
    int         steps;
    logic [7:0] exp_int;
    logic [7:0] exp_vfmt;
    logic [1:0] exp_grant;
  } vec_t;

  logic        clk_50mhz_in  = 1'b0;
  logic        reset_x       = 1'b1;
  logic        skip_init     = 1'b0;
  logic        id_read_a     = 1'b0;
  logic        irq_clr_tgl_a = 1'b0;
  logic [7:0]  video_format  = 8'd0;
  logic [1:0]  ext_req       = 2'b00;
  logic [15:0] ext_code      = {8'hBF, 8'hF7};
  logic [1:0]  ext_grant;
  logic [7:0]  int_reg;
  logic        int_pending;
  logic [7:0]  reg_video_format;
  logic [7:0]  elapsed_s;
  logic        init_done;
`ifdef BKM_IRQ_RETRY_EN
  logic        irq_lost;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc;
  int g0_cnt   = 0;
  int g1_cnt   = 0;
  vec_t vecs[$];

  bkm_irq_scheduler #(
    .CLK_HZ     (CLK_HZ),
    .ANNOUNCE_S (12),
    .READY_S    (19),
    .NUM_REQ    (2),
    .RETRY_S    (2)
  ) dut (
    .clk_50mhz_in     (clk_50mhz_in),
    .reset_x          (reset_x),
    .skip_init        (skip_init),
    .id_read_a        (id_read_a),
    .irq_clr_tgl_a    (irq_clr_tgl_a),
    .video_format     (video_format),
    .ext_req          (ext_req),
    .ext_code         (ext_code),
    .ext_grant        (ext_grant),
    .int_reg          (int_reg),
    .int_pending      (int_pending),
    .reg_video_format (reg_video_format),
    .elapsed_s        (elapsed_s),
`ifdef BKM_IRQ_RETRY_EN
    .init_done        (init_done),
    .irq_lost         (irq_lost)
`else
    .init_done        (init_done)
`endif
  );

  always #5 clk_50mhz_in = ~clk_50mhz_in;

  // Reference cycle count since reset release; elapsed_s should be cyc/100.
  always @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk_50mhz_in) begin
    if (reset_x) begin
      if (ext_grant[0]) g0_cnt <= g0_cnt + 1;
      if (ext_grant[1]) g1_cnt <= g1_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_50mhz_in);
    #1;
  endtask

  task automatic runTo(input int n);
    while (cyc < n) step();
  endtask

  task automatic toggleClear();
    irq_clr_tgl_a = ~irq_clr_tgl_a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    video_format = v.vfmt;
    ext_req      = v.req;
    if (v.clr) toggleClear();
  endtask

  function automatic vec_t mk(input logic clr, input logic [1:0] req, input logic [7:0] vfmt,
                              input int steps, input logic [7:0] ei, input logic [7:0] ev,
                              input logic [1:0] eg);
    vec_t v;
    v.clr = clr; v.req = req; v.vfmt = vfmt; v.steps = steps;
    v.exp_int = ei; v.exp_vfmt = ev; v.exp_grant = eg;
    return v;
  endfunction

  initial begin
    int reposts;
    int nonff;
    logic [7:0] prev;

    // S_RUN vectors, starting with 0xEF posted and reg_video_format=0.
    vecs.push_back(mk(1, 2'b00, 8'd0, 2, 8'hEF, 8'd0, 2'b00)); // clear not yet through
    vecs.push_back(mk(0, 2'b00, 8'd0, 1, 8'hFF, 8'd0, 2'b00)); // third cycle: cleared
    vecs.push_back(mk(0, 2'b00, 8'd3, 1, 8'hDF, 8'd3, 2'b00)); // format 0->3
    vecs.push_back(mk(1, 2'b00, 8'd3, 3, 8'hFF, 8'd3, 2'b00));
    vecs.push_back(mk(0, 2'b11, 8'd1, 1, 8'hDF, 8'd1, 2'b00)); // format 3->1 + both reqs
    vecs.push_back(mk(1, 2'b00, 8'd1, 3, 8'hFF, 8'd1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 8'd1, 1, 8'hF7, 8'd1, 2'b01)); // req0 first
    vecs.push_back(mk(0, 2'b00, 8'd1, 1, 8'hF7, 8'd1, 2'b00)); // grant is one cycle
    vecs.push_back(mk(1, 2'b00, 8'd1, 3, 8'hFF, 8'd1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 8'd1, 1, 8'hBF, 8'd1, 2'b01 << 1)); // then req1
    vecs.push_back(mk(0, 2'b00, 8'd4, 1, 8'hBF, 8'd1, 2'b00)); // format flips while busy
    vecs.push_back(mk(0, 2'b00, 8'd1, 1, 8'hBF, 8'd1, 2'b00)); // and reverts
    vecs.push_back(mk(1, 2'b00, 8'd1, 3, 8'hFF, 8'd1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 8'd1, 2, 8'hFF, 8'd1, 2'b00)); // reverted format not posted
    vecs.push_back(mk(0, 2'b00, 8'd2, 1, 8'hDF, 8'd2, 2'b00));
    vecs.push_back(mk(0, 2'b01, 8'd2, 1, 8'hDF, 8'd2, 2'b00)); // req0 twice while busy
    vecs.push_back(mk(0, 2'b01, 8'd2, 1, 8'hDF, 8'd2, 2'b00));
    vecs.push_back(mk(1, 2'b00, 8'd2, 3, 8'hFF, 8'd2, 2'b00));
    vecs.push_back(mk(0, 2'b00, 8'd2, 1, 8'hF7, 8'd2, 2'b01));
    vecs.push_back(mk(1, 2'b10, 8'd2, 3, 8'hFF, 8'd2, 2'b00)); // clear + req same cycle
    vecs.push_back(mk(0, 2'b00, 8'd2, 1, 8'hBF, 8'd2, 2'b10)); // posted one cycle after
    vecs.push_back(mk(1, 2'b00, 8'd2, 3, 8'hFF, 8'd2, 2'b00));
    vecs.push_back(mk(0, 2'b00, 8'd2, 2, 8'hFF, 8'd2, 2'b00)); // merged req0 not reposted

    // Asynchronous reset values
    #1 reset_x = 1'b0;
    #2;
    checkOutput("rst int_reg", int_reg, 8'hFD);
    checkOutput("rst int_pending", int_pending, 1);
    checkOutput("rst reg_video_format", reg_video_format, 8'h00);
    checkOutput("rst elapsed_s", elapsed_s, 0);
    checkOutput("rst ext_grant", ext_grant, 0);
    checkOutput("rst init_done", init_done, 0);
`ifdef BKM_IRQ_RETRY_EN
    checkOutput("rst irq_lost", irq_lost, 0);
`endif
    step();
    step();
    reset_x = 1'b1;

    // Power-on event cleared: three-cycle latency
    runTo(10);
    toggleClear();
    step(); step();
    checkOutput("poweron clr at 2 cycles", int_reg, 8'hFD);
    step();
    checkOutput("poweron clr at 3 cycles", int_reg, 8'hFF);
    checkOutput("poweron int_pending", int_pending, 0);

    // Announce: ID read at 5 s, posted once elapsed_s exceeds 12
    runTo(500);
    id_read_a = 1'b1;
    runTo(1300);
    checkOutput("elapsed_s at 13 s", elapsed_s, 13);
    checkOutput("announce not before 13 s", int_reg, 8'hFF);
    step();
    checkOutput("announce posted", int_reg, 8'hFB);
    checkOutput("init_done during announce", init_done, 0);
    runTo(1450);
    toggleClear();
    step(); step(); step();
    checkOutput("announce cleared", int_reg, 8'hFF);
    runTo(2000);
    checkOutput("elapsed_s at 20 s", elapsed_s, 20);
    checkOutput("ready not before 20 s", int_reg, 8'hFF);
    checkOutput("init_done before ready", init_done, 0);
    step();
    checkOutput("ready posted", int_reg, 8'hEF);
    checkOutput("init_done after ready", init_done, 1);
    checkOutput("ready int_pending", int_pending, 1);

    // Table-driven S_RUN vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      for (int s = 0; s < vecs[i].steps; s++) begin
        step();
        ext_req = 2'b00;
      end
      checkOutput($sformatf("vec%0d int_reg", i), int_reg, vecs[i].exp_int);
      checkOutput($sformatf("vec%0d reg_video_format", i), reg_video_format, vecs[i].exp_vfmt);
      checkOutput($sformatf("vec%0d ext_grant", i), ext_grant, vecs[i].exp_grant);
    end

    // Reset mid-operation with a request latched; then skip_init boot
    video_format = 8'd0;
    step();
    checkOutput("pre-reset format post", int_reg, 8'hDF);
    ext_req = 2'b10;
    step();
    ext_req = 2'b00;
    #2 reset_x = 1'b0;
    #1;
    checkOutput("mid reset int_reg", int_reg, 8'hFD);
    checkOutput("mid reset init_done", init_done, 0);
    checkOutput("mid reset elapsed_s", elapsed_s, 0);
    skip_init     = 1'b1;
    irq_clr_tgl_a = 1'b0;
    step();
    reset_x = 1'b1;
    step();
    checkOutput("skip_init init_done", init_done, 1);
    checkOutput("skip_init int_reg", int_reg, 8'hFD);
    toggleClear();
    step(); step(); step();
    checkOutput("skip_init clear", int_reg, 8'hFF);
    step(); step();
    checkOutput("lost latch no post", int_reg, 8'hFF);
    checkOutput("grant0 count", g0_cnt, 2);
    checkOutput("grant1 count", g1_cnt, 2);
    video_format = 8'd3;
    step();
    checkOutput("skip_init format post", int_reg, 8'hDF);
    checkOutput("skip_init reg_video_format", reg_video_format, 8'h03);

`ifdef BKM_IRQ_RETRY_EN
    // Uncleared post: three reposts, then dropped with irq_lost
    reposts = 0;
    prev    = int_reg;
    for (int k = 0; k < 1200 && !irq_lost; k++) begin
      step();
      if (prev == 8'hFF && int_reg == 8'hDF) reposts++;
      prev = int_reg;
    end
    checkOutput("retry repost count", reposts, 3);
    checkOutput("retry irq_lost", irq_lost, 1);
    checkOutput("retry dropped int_reg", int_reg, 8'hFF);

    // A clear before the timeout cancels any retry
    video_format = 8'd4;
    step();
    checkOutput("retry2 posted", int_reg, 8'hDF);
    repeat (50) step();
    checkOutput("retry2 still up", int_reg, 8'hDF);
    toggleClear();
    step(); step(); step();
    checkOutput("retry2 cleared", int_reg, 8'hFF);
    nonff = 0;
    repeat (400) begin
      step();
      if (int_reg != 8'hFF) nonff++;
    end
    checkOutput("retry2 no repost", nonff, 0);
`endif

    // Seconds counter saturation
    runTo(25400);
    checkOutput("elapsed_s at 254 s", elapsed_s, 254);
    runTo(25700);
    checkOutput("elapsed_s saturates", elapsed_s, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
